// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects N push buttons; btn_clean follows a stable
// btn_raw after DEBOUNCE_CYCLES+2 edges, with rise/fall pulses registered alongside it.
module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_clean,
  output logic [N_BUTTONS-1:0] btn_rise,
  output logic [N_BUTTONS-1:0] btn_fall,
  output logic [N_BUTTONS-1:0] btn_toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_BUTTONS-1:0] sync1_q, sync2_q;
  logic [N_BUTTONS-1:0] clean_q, clean_d;
  logic [N_BUTTONS-1:0] rise_q, rise_d;
  logic [N_BUTTONS-1:0] fall_q, fall_d;
  logic [N_BUTTONS-1:0] toggle_q, toggle_d;
  logic [CW-1:0]        cnt_q [N_BUTTONS];
  logic [CW-1:0]        cnt_d [N_BUTTONS];

  always_comb begin
    clean_d  = clean_q;
    rise_d   = '0;
    fall_d   = '0;
    toggle_d = toggle_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      // Any cycle agreeing with the accepted level leaves the count at zero.
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i]  = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
          toggle_d[i] = toggle_q[i] ^ sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      clean_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      for (int i = 0; i < N_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_clean  = clean_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign btn_toggle = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window: directed vectors, corner
// sequences and a randomized run against a history-based reference model.
module tb_button_conditioner;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_clean, btn_rise, btn_fall, btn_toggle;

  int total = 0;
  int bad   = 0;

  button_conditioner #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_toggle(btn_toggle)
  );

  always #5 clk = ~clk;

  // Reference model: a new level is accepted once the last D synchronized samples
  // (taken since the previous acceptance or reset) all differ from the current level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_tog = '0;
  bit           hist [N][$];

  task automatic model_edge(input logic [N-1:0] r, input logic rs);
    bit all_diff;
    if (rs) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_tog = '0;
      for (int i = 0; i < N; i++) hist[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        hist[i].push_back(m_s2[i]);
        if (hist[i].size() > D) void'(hist[i].pop_front());
        all_diff = (hist[i].size() == D);
        foreach (hist[i][k]) if (hist[i][k] == m_clean[i]) all_diff = 0;
        if (all_diff) begin
          m_clean[i] = ~m_clean[i];
          if (m_clean[i]) begin
            m_rise[i] = 1'b1;
            m_tog[i]  = ~m_tog[i];
          end else begin
            m_fall[i] = 1'b1;
          end
          hist[i].delete();
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rs);
    btn_raw = r;
    rst     = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (clean,rise,fall,toggle nibbles)", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [N-1:0] c, input logic [N-1:0] r,
                         input logic [N-1:0] f, input logic [N-1:0] t);
    cmp(nm, {btn_clean, btn_rise, btn_fall, btn_toggle}, {c, r, f, t});
  endtask

  typedef struct {
    logic         rs;
    logic [N-1:0] raw;
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] tog;
  } vec_t;

  vec_t tbl [19];
  logic [N-1:0] rnd_raw;
  int rise_cnt;

  initial begin
    // Reset, idle, press of button 0, then a too-short pulse on button 1.
    for (int j = 0; j < 19; j++) begin
      tbl[j].rs = (j < 2);
      tbl[j].raw = (j < 5) ? 4'b0000 : ((j >= 12 && j <= 14) ? 4'b0011 : 4'b0001);
      tbl[j].clean = (j >= 10) ? 4'b0001 : 4'b0000;
      tbl[j].rise  = (j == 10) ? 4'b0001 : 4'b0000;
      tbl[j].fall  = 4'b0000;
      tbl[j].tog   = (j >= 10) ? 4'b0001 : 4'b0000;
    end
    for (int j = 0; j < 19; j++) begin
      step(tbl[j].raw, tbl[j].rs);
      chk_out($sformatf("tbl%0d", j), tbl[j].clean, tbl[j].rise, tbl[j].fall, tbl[j].tog);
    end

    // Valid press and release of button 1: rise then a single fall, toggle kept.
    for (int k = 1; k <= 8; k++) begin
      step(4'b0011, 1'b0);
      if (k == 5) chk_out("b1_press_e5", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      if (k == 6) chk_out("b1_press_e6", 4'b0011, 4'b0010, 4'b0000, 4'b0011);
      if (k == 7) chk_out("b1_press_e7", 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 1'b0);
      if (k == 5) chk_out("b1_rel_e5", 4'b0011, 4'b0000, 4'b0000, 4'b0011);
      if (k == 6) chk_out("b1_rel_e6", 4'b0001, 4'b0000, 4'b0010, 4'b0011);
      if (k == 7) chk_out("b1_rel_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0011);
    end

    // Bounce on button 2: 1,0 then held; acceptance 6 edges after the last 0->1.
    rise_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step((k == 1) ? 4'b0001 : 4'b0101, 1'b0);
      if (btn_rise[2]) rise_cnt++;
      if (k == 6) chk_out("bounce_e6", 4'b0001, 4'b0000, 4'b0000, 4'b0011);
      if (k == 7) chk_out("bounce_e7", 4'b0101, 4'b0100, 4'b0000, 4'b0111);
    end
    cmp("bounce_rise_count", 16'(rise_cnt), 16'd1);
    for (int k = 0; k < 7; k++) step(4'b0001, 1'b0);
    chk_out("b2_released", 4'b0001, 4'b0000, 4'b0000, 4'b0111);

    // Two presses of button 3 toggle it on then off.
    for (int k = 0; k < 7; k++) step(4'b1001, 1'b0);
    chk_out("b3_press1", 4'b1001, 4'b0000, 4'b0000, 4'b1111);
    for (int k = 0; k < 7; k++) step(4'b0001, 1'b0);
    chk_out("b3_rel1", 4'b0001, 4'b0000, 4'b0000, 4'b1111);
    for (int k = 0; k < 7; k++) step(4'b1001, 1'b0);
    chk_out("b3_press2", 4'b1001, 4'b0000, 4'b0000, 4'b0111);
    for (int k = 0; k < 7; k++) step(4'b0000, 1'b0);
    chk_out("all_released", 4'b0000, 4'b0000, 4'b0000, 4'b0111);

    // Simultaneous press and release of all channels.
    for (int k = 1; k <= 7; k++) begin
      step(4'b1111, 1'b0);
      if (k == 6) chk_out("all_press_e6", 4'b1111, 4'b1111, 4'b0000, 4'b1000);
      if (k == 7) chk_out("all_press_e7", 4'b1111, 4'b0000, 4'b0000, 4'b1000);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000, 1'b0);
      if (k == 6) chk_out("all_rel_e6", 4'b0000, 4'b0000, 4'b1111, 4'b1000);
    end

    // Reset in the middle of a pending press of button 0, button held throughout.
    for (int k = 0; k < 4; k++) step(4'b0001, 1'b0);
    chk_out("pre_rst_cnt2", 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    for (int k = 0; k < 2; k++) begin
      step(4'b0001, 1'b1);
      chk_out($sformatf("mid_rst%0d", k), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 1'b0);
      if (k == 5) chk_out("post_rst_e5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      if (k == 6) chk_out("post_rst_e6", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      if (k == 7) chk_out("post_rst_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    end

    // Randomized bouncy stimulus with occasional resets.
    rnd_raw = 4'b0001;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) rnd_raw[i] = ~rnd_raw[i];
      step(rnd_raw, ($urandom_range(0, 299) == 0));
      chk_out("rand", m_clean, m_rise, m_fall, m_tog);
      cmp("rand_rise_fall_excl", {12'd0, btn_rise & btn_fall}, 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw board push buttons before they reach the LED switch-group block. Each button is synchronized into the clock domain, debounced with a per-button stability counter, and presented as a clean level, single-cycle rise/fall pulses and a press-toggled latch. The clean level bit i drives push_button_i of the LED block directly; the pulses and toggles serve downstream logic that needs edge or latched semantics.

## Interface
- N_BUTTONS, 4, number of independent button channels (bit i = button i)
- DEBOUNCE_CYCLES, 100000, consecutive stable synchronized cycles required to accept a new level; legal range >= 1 (10 ms at 10 MHz)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- btn_raw  input  N_BUTTONS  asynchronous, bouncy button inputs, 1 = pressed
- btn_clean  output  N_BUTTONS  debounced level, 1 = pressed
- btn_rise  output  N_BUTTONS  one-cycle pulse when btn_clean goes 0->1
- btn_fall  output  N_BUTTONS  one-cycle pulse when btn_clean goes 1->0
- btn_toggle  output  N_BUTTONS  flips on every accepted press (rise)

## Operation
- Per channel: 2-flop synchronizer, sync1 <= btn_raw[i], sync2 <= sync1; only sync2 is used downstream.
- Counter cnt, width $clog2(DEBOUNCE_CYCLES+1), per channel; channels fully independent.
- Each cycle, per channel:
  - sync2 == btn_clean: cnt <= 0 (any agreeing cycle aborts a pending change; glitch rejection).
  - sync2 != btn_clean and cnt == DEBOUNCE_CYCLES-1: btn_clean <= sync2, cnt <= 0, assert btn_rise or btn_fall per direction.
  - otherwise cnt <= cnt+1.
- btn_rise/btn_fall are registered, high exactly the cycle after btn_clean changes... defined precisely: they update on the same edge as btn_clean and are cleared on the next edge. Never both high on one channel.
- btn_toggle[i] <= ~btn_toggle[i] on the edge where btn_rise[i] is set; fall has no effect.
- No saturation issue: cnt never exceeds DEBOUNCE_CYCLES-1.

## Timing
- Reset (rst high at a rising edge): sync1, sync2, cnt, btn_clean, btn_rise, btn_fall, btn_toggle all 0 after that edge; rst dominates all other activity.
- Latency: btn_raw changes before edge 1 and stays stable; btn_clean and the pulse change after edge DEBOUNCE_CYCLES+2 (2 sync edges + DEBOUNCE_CYCLES count edges). Pulse deasserts after edge DEBOUNCE_CYCLES+3.
- Bounce: any return of sync2 to btn_clean for >= 1 cycle restarts the full count.
- Button held through reset: after rst drops, treated as a new press; btn_clean rises DEBOUNCE_CYCLES+2 edges after first non-reset edge, with btn_rise pulse and toggle flip.
- Reset mid-count: pending change discarded, no pulse emitted.
- Simultaneous presses on several channels: each channel reports independently on the same cycle if timing is equal.
- DEBOUNCE_CYCLES = 1: new level accepted after exactly one disagreeing synchronized cycle (latency 3 edges).

## Test plan
- DEBOUNCE_CYCLES=4, rst 2 cycles, btn_raw=0000 -> all outputs 0 throughout.
- btn_raw[0] 0->1 before edge 1, held -> btn_clean=0001 and btn_rise=0001 after edge 6, btn_rise=0000 after edge 7, btn_toggle=0001.
- btn_raw[1] pulses 1 for 3 cycles then 0 (shorter than 4 stable) -> btn_clean[1], btn_rise[1] stay 0; then release after valid press -> btn_fall[1] single pulse, btn_toggle[1] unchanged.
- Bounce pattern 1,0,1,1,1,1,1 on btn_raw[2] -> count restarts at the 0; btn_clean[2] rises 6 edges after the last 0->1 transition, exactly one btn_rise pulse.
- Two valid presses of btn_raw[3] -> btn_toggle[3] goes 1 then 0; btn_raw=1111 simultaneously -> btn_rise=1111 on one cycle.
- rst asserted at cnt=2 with btn_raw[0]=1 held -> no pulse during reset, all outputs 0; after rst release btn_clean[0] rises 6 edges later with one btn_rise pulse.
